inst_fetch_ctrl: RTL and testbench

Fetch sequencer for the 8-bit accumulator-style core. It owns the program counter and drives the combinational instruction ROM. After reset it pre-scans the ROM to build a label table from `1111_llll` label markers. It then streams instructions to decode over a valid/ready handshake, resolving label-indexed branches, skipping label markers, and stopping on halt (`8'hE0`) or on a fault.

---
 rtl/inst_fetch_ctrl.sv | 159 +++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction fetch sequencer with ROM label pre-scan and branch resolution
module inst_fetch_ctrl #(
    parameter int unsigned SCAN_DEPTH = 256,
    parameter logic [7:0]  HALT_OPC   = 8'hE0,
    parameter logic [7:0]  FILL_OPC   = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    output logic [7:0] rom_addr_o,
    input  logic [7:0] rom_data_i,
    input  logic       start_i,
    output logic [7:0] inst_o,
    output logic [7:0] inst_pc_o,
    output logic       inst_valid_o,
    input  logic       inst_ready_i,
    input  logic       branch_valid_i,
    input  logic [3:0] branch_label_i,
    output logic       scan_done_o,
    output logic       done_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_t;

    localparam logic [7:0] SCAN_LAST = 8'(SCAN_DEPTH - 1);

    state_t      state;
    logic [7:0]  scan_cnt;
    logic [7:0]  pc;
    logic [7:0]  lbl_addr [0:14];
    logic [14:0] lbl_found;
    // settle: one dead cycle after start/branch before the first fetch at the new PC
    logic        settle;
    // halt_pend: the halt instruction sits in the output slot, fetching is frozen
    logic        halt_pend;

    logic        is_label;
    logic        xfer;
    logic        slot_free;
    logic        lbl_hit;
    logic [7:0]  lbl_tgt;

    // Instruction classification and branch-target lookup
    always_comb begin
        is_label  = (rom_data_i[7:4] == 4'hF) && (rom_data_i != FILL_OPC);
        xfer      = inst_valid_o && inst_ready_i;
        slot_free = !inst_valid_o || xfer;
        lbl_hit   = 1'b0;
        lbl_tgt   = 8'h00;
        if (branch_label_i != 4'hF) begin
            lbl_hit = lbl_found[branch_label_i];
            lbl_tgt = lbl_addr[branch_label_i] + 8'd1;
        end
    end

    // ROM address: scan counter while scanning, PC while running or halted
    always_comb begin
        case (state)
            ST_SCAN:           rom_addr_o = scan_cnt;
            ST_RUN, ST_HALTED: rom_addr_o = pc;
            default:           rom_addr_o = 8'h00;
        endcase
    end

    // Main sequencer: label scan, fetch/issue, branch redirect, halt and faults
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= ST_SCAN;
            scan_cnt     <= 8'h00;
            pc           <= 8'h00;
            lbl_found    <= '0;
            for (int i = 0; i < 15; i++) begin
                lbl_addr[i] <= 8'h00;
            end
            settle       <= 1'b0;
            halt_pend    <= 1'b0;
            inst_o       <= 8'h00;
            inst_pc_o    <= 8'h00;
            inst_valid_o <= 1'b0;
            scan_done_o  <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            case (state)
                ST_SCAN: begin
                    if (is_label && (rom_data_i[3:0] != 4'hF) && !lbl_found[rom_data_i[3:0]]) begin
                        lbl_addr[rom_data_i[3:0]]  <= scan_cnt;
                        lbl_found[rom_data_i[3:0]] <= 1'b1;
                    end
                    if (scan_cnt == SCAN_LAST) begin
                        state       <= ST_IDLE;
                        scan_done_o <= 1'b1;
                    end else begin
                        scan_cnt <= scan_cnt + 8'd1;
                    end
                end
                ST_IDLE, ST_HALTED: begin
                    if (start_i) begin
                        state     <= ST_RUN;
                        pc        <= 8'h00;
                        err_o     <= 1'b0;
                        done_o    <= 1'b0;
                        settle    <= 1'b1;
                        halt_pend <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (branch_valid_i) begin
                        inst_valid_o <= 1'b0;
                        halt_pend    <= 1'b0;
                        if (lbl_hit) begin
                            pc     <= lbl_tgt;
                            settle <= 1'b1;
                        end else begin
                            err_o  <= 1'b1;
                            done_o <= 1'b1;
                            state  <= ST_HALTED;
                        end
                    end else if (halt_pend) begin
                        if (xfer) begin
                            inst_valid_o <= 1'b0;
                            halt_pend    <= 1'b0;
                            done_o       <= 1'b1;
                            state        <= ST_HALTED;
                        end
                    end else if (settle) begin
                        settle <= 1'b0;
                    end else if (slot_free) begin
                        if (is_label) begin
                            inst_valid_o <= 1'b0;
                            pc           <= pc + 8'd1;
                        end else if (rom_data_i == FILL_OPC) begin
                            inst_valid_o <= 1'b0;
                            err_o        <= 1'b1;
                            done_o       <= 1'b1;
                            state        <= ST_HALTED;
                        end else begin
                            inst_o       <= rom_data_i;
                            inst_pc_o    <= pc;
                            inst_valid_o <= 1'b1;
                            if (rom_data_i == HALT_OPC) begin
                                halt_pend <= 1'b1;
                            end else begin
                                pc <= pc + 8'd1;
                            end
                        end
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - self-checking bench for inst_fetch_ctrl
module tb_inst_fetch_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [7:0] rom_addr_o;
    logic [7:0] rom_data_i;
    logic       start_i;
    logic [7:0] inst_o;
    logic [7:0] inst_pc_o;
    logic       inst_valid_o;
    logic       inst_ready_i;
    logic       branch_valid_i;
    logic [3:0] branch_label_i;
    logic       scan_done_o;
    logic       done_o;
    logic       err_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];
    logic [7:0]  rom [0:255];

    assign rom_data_i = rom[rom_addr_o];

    always #5 clk_i = ~clk_i;

    inst_fetch_ctrl dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .rom_addr_o     (rom_addr_o),
        .rom_data_i     (rom_data_i),
        .start_i        (start_i),
        .inst_o         (inst_o),
        .inst_pc_o      (inst_pc_o),
        .inst_valid_o   (inst_valid_o),
        .inst_ready_i   (inst_ready_i),
        .branch_valid_i (branch_valid_i),
        .branch_label_i (branch_label_i),
        .scan_done_o    (scan_done_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    // One clock: at the falling edge score any transfer the next rising edge will take
    task automatic cycle();
        logic [15:0] e;
        @(negedge clk_i);
        if (rst_n_i && inst_valid_o && inst_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected: got pc=%h inst=%h, required none", inst_pc_o, inst_o);
            end else begin
                e = exp_q.pop_front();
                if ({inst_pc_o, inst_o} !== e) begin
                    errors++;
                    $display("FAIL xfer: got pc/inst=%h, required %h", {inst_pc_o, inst_o}, e);
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    // Expected issue stream for a straight-line run: label markers are never issued
    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (!(rom[i][7:4] == 4'hF && rom[i] != 8'hFF)) begin
                exp_q.push_back({8'(i), rom[i]});
            end
        end
    endtask

    task automatic test_reset();
        rst_n_i        = 1'b0;
        start_i        = 1'b0;
        inst_ready_i   = 1'b0;
        branch_valid_i = 1'b0;
        branch_label_i = 4'h0;
        #1;
        exp_q.delete();
        checks++;
        if ({inst_o, inst_pc_o, inst_valid_o, scan_done_o, done_o, err_o} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {inst_o, inst_pc_o, inst_valid_o, scan_done_o, done_o, err_o});
        end
        checks++;
        if (rom_addr_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_rom_addr: got %h, required 00", rom_addr_o);
        end
        cycle();
        cycle();
        rst_n_i = 1'b1;
    endtask

    task automatic test_scan();
        int n = 0;
        int addr_bad = 0;
        while (!scan_done_o && n < 300) begin
            if (rom_addr_o !== 8'(n)) addr_bad++;
            cycle();
            n++;
        end
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL scan_len: got %0d cycles, required 256", n);
        end
        checks++;
        if (addr_bad != 0) begin
            errors++;
            $display("FAIL scan_addr: got %0d bad addresses, required 0", addr_bad);
        end
        checks++;
        if (rom_addr_o !== 8'h00 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_state: got addr=%h done=%b, required 00/0", rom_addr_o, done_o);
        end
    endtask

    task automatic test_stream();
        logic       ev;
        logic [7:0] ep;
        inst_ready_i = 1'b1;
        push_range(0, 10);
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        checks++;
        if (rom_addr_o !== 8'h00 || inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL start_addr: got addr=%h valid=%b, required 00/0", rom_addr_o, inst_valid_o);
        end
        for (int k = 1; k <= 14; k++) begin
            cycle();
            ev = (k >= 2 && k <= 12) || k == 14;
            ep = (k <= 12) ? 8'(k - 2) : 8'h0C;
            checks++;
            if (inst_valid_o !== ev || (ev && inst_pc_o !== ep)) begin
                errors++;
                $display("FAIL stream_k%0d: got valid=%b pc=%h, required %b/%h", k, inst_valid_o, inst_pc_o, ev, ep);
            end
        end
        checks++;
        if (inst_o !== 8'h92) begin
            errors++;
            $display("FAIL stream_inst_0c: got %h, required 92", inst_o);
        end
        inst_ready_i = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_drained: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_branch();
        int n = 0;
        cycle();
        checks++;
        if (inst_valid_o !== 1'b1 || inst_pc_o !== 8'h0C) begin
            errors++;
            $display("FAIL pending_hold: got valid=%b pc=%h, required 1/0c", inst_valid_o, inst_pc_o);
        end
        branch_valid_i = 1'b1;
        branch_label_i = 4'd8;
        cycle();
        branch_valid_i = 1'b0;
        checks++;
        if (inst_valid_o !== 1'b0 || rom_addr_o !== 8'h39) begin
            errors++;
            $display("FAIL branch_flush: got valid=%b addr=%h, required 0/39", inst_valid_o, rom_addr_o);
        end
        while (!inst_valid_o && n < 10) begin
            cycle();
            n++;
        end
        checks++;
        if (n != 2 || inst_pc_o !== 8'h39 || inst_o !== 8'hC0) begin
            errors++;
            $display("FAIL branch_target: got lat=%0d pc=%h inst=%h, required 2/39/c0", n, inst_pc_o, inst_o);
        end
    endtask

    task automatic test_halt();
        int n = 0;
        push_range(8'h39, 8'h3E);
        inst_ready_i = 1'b1;
        while (!done_o && n < 30) begin
            cycle();
            n++;
        end
        checks++;
        if (n != 6 || err_o !== 1'b0 || inst_valid_o !== 1'b0 || rom_addr_o !== 8'h3E) begin
            errors++;
            $display("FAIL halt: got cyc=%0d err=%b valid=%b addr=%h, required 6/0/0/3e",
                     n, err_o, inst_valid_o, rom_addr_o);
        end
        repeat (3) cycle();
        checks++;
        if (inst_valid_o !== 1'b0 || done_o !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL halt_stay: got valid=%b done=%b left=%0d, required 0/1/0",
                     inst_valid_o, done_o, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic [7:0] h_inst, h_pc, h_addr;
        push_range(0, 10);
        inst_ready_i = 1'b1;
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        checks++;
        if (done_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL restart_flags: got done=%b err=%b, required 0/0", done_o, err_o);
        end
        cycle();
        cycle();
        checks++;
        if (inst_valid_o !== 1'b1 || inst_pc_o !== 8'h00) begin
            errors++;
            $display("FAIL restart_latency: got valid=%b pc=%h, required 1/00", inst_valid_o, inst_pc_o);
        end
        while (!(inst_valid_o && inst_pc_o == 8'h05) && n < 20) begin
            cycle();
            n++;
        end
        h_inst = inst_o;
        h_pc   = inst_pc_o;
        h_addr = rom_addr_o;
        inst_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (inst_valid_o !== 1'b1 || inst_o !== 8'h15 || inst_pc_o !== 8'h05 || rom_addr_o !== 8'h06
                || h_inst !== 8'h15 || h_pc !== 8'h05 || h_addr !== 8'h06) begin
                errors++;
                $display("FAIL bp_hold%0d: got inst=%h pc=%h addr=%h, required 15/05/06",
                         k, inst_o, inst_pc_o, rom_addr_o);
            end
        end
        inst_ready_i = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 30) begin
            cycle();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_branch_dup();
        int n = 0;
        inst_ready_i = 1'b0;
        cycle();
        branch_valid_i = 1'b1;
        branch_label_i = 4'd1;
        cycle();
        branch_valid_i = 1'b0;
        checks++;
        if (inst_valid_o !== 1'b0 || rom_addr_o !== 8'h26) begin
            errors++;
            $display("FAIL dup_target_addr: got valid=%b addr=%h, required 0/26", inst_valid_o, rom_addr_o);
        end
        while (!inst_valid_o && n < 10) begin
            cycle();
            n++;
        end
        checks++;
        if (n != 2 || inst_pc_o !== 8'h26 || inst_o !== 8'h36) begin
            errors++;
            $display("FAIL dup_target: got lat=%0d pc=%h inst=%h, required 2/26/36", n, inst_pc_o, inst_o);
        end
    endtask

    task automatic test_fault_label(input logic [3:0] lbl);
        branch_valid_i = 1'b1;
        branch_label_i = lbl;
        cycle();
        branch_valid_i = 1'b0;
        checks++;
        if (err_o !== 1'b1 || done_o !== 1'b1 || inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL fault_label%0d: got err=%b done=%b valid=%b, required 1/1/0",
                     lbl, err_o, done_o, inst_valid_o);
        end
    endtask

    task automatic test_fault_fill();
        int n = 0;
        rom[8'h3E] = 8'h55;
        inst_ready_i = 1'b0;
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        checks++;
        if (err_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got err=%b done=%b, required 0/0", err_o, done_o);
        end
        branch_valid_i = 1'b1;
        branch_label_i = 4'd8;
        cycle();
        branch_valid_i = 1'b0;
        push_range(8'h39, 8'h3E);
        inst_ready_i = 1'b1;
        while (!done_o && n < 30) begin
            cycle();
            n++;
        end
        checks++;
        if (err_o !== 1'b1 || inst_valid_o !== 1'b0 || rom_addr_o !== 8'h3F || exp_q.size() != 0) begin
            errors++;
            $display("FAIL fault_fill: got err=%b valid=%b addr=%h left=%0d, required 1/0/3f/0",
                     err_o, inst_valid_o, rom_addr_o, exp_q.size());
        end
        rom[8'h3E] = 8'hE0;
    endtask

    task automatic test_reset_midrun();
        push_range(0, 10);
        inst_ready_i = 1'b1;
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        repeat (5) cycle();
        checks++;
        if (inst_valid_o !== 1'b1 || inst_pc_o !== 8'h03) begin
            errors++;
            $display("FAIL midrun: got valid=%b pc=%h, required 1/03", inst_valid_o, inst_pc_o);
        end
        test_reset();
        test_scan();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = (i <= 8'h3D) ? 8'(8'h10 + i) : 8'hFF;
        end
        rom[8'h0B] = 8'hF0;
        rom[8'h0C] = 8'h92;
        rom[8'h25] = 8'hF1;
        rom[8'h38] = 8'hF8;
        rom[8'h39] = 8'hC0;
        rom[8'h3E] = 8'hE0;
        rom[8'h40] = 8'hF1;

        test_reset();
        test_scan();
        test_stream();
        test_branch();
        test_halt();
        test_backpressure();
        test_branch_dup();
        test_fault_label(4'd5);
        test_fault_fill();
        test_reset_midrun();
        inst_ready_i = 1'b0;
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        test_fault_label(4'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
